// File: rtl/laser_pkg.sv
// laser_pkg: shared widths, FSM state encoding, coordinate type and window-bound helpers.
package laser_pkg;

    localparam int unsigned COORD_W  = 4;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned NPTS     = 40;
    localparam int unsigned GRID_MAX = 15;

    typedef enum logic [2:0] {
        IDLE,
        SCAN1,
        SCAN2,
        REF1,
        REF2,
        FIN
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    // Lower window edge on one axis, clamped at 0.
    function automatic logic [COORD_W-1:0] axis_lo(input logic [COORD_W-1:0] c,
                                                   input logic [COORD_W-1:0] w);
        return (c > w) ? COORD_W'(c - w) : '0;
    endfunction

    // Upper window edge on one axis, clamped at the grid edge.
    function automatic logic [COORD_W-1:0] axis_hi(input logic [COORD_W-1:0] c,
                                                   input logic [COORD_W-1:0] w);
        logic [COORD_W:0] s;
        s = {1'b0, c} + {1'b0, w};
        return (s > (COORD_W+1)'(GRID_MAX)) ? COORD_W'(GRID_MAX) : s[COORD_W-1:0];
    endfunction

    function automatic coord_t win_lo(input coord_t c, input logic [COORD_W-1:0] w);
        return {axis_lo(c.x, w), axis_lo(c.y, w)};
    endfunction

    function automatic coord_t win_hi(input coord_t c, input logic [COORD_W-1:0] w);
        return {axis_hi(c.x, w), axis_hi(c.y, w)};
    endfunction

endpackage

// File: rtl/laser_win_gen.sv
// laser_win_gen: raster generator over a rectangular window, x inner and y outer.
// load latches the bounds and restarts at lo; step advances one grid point.
module laser_win_gen
    import laser_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   load,
    input  logic   step,
    input  coord_t lo,
    input  coord_t hi,
    output coord_t pos,
    output logic   last_c
);

    coord_t lo_q;
    coord_t hi_q;

    // Bounds latch and raster position.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lo_q <= '0;
            hi_q <= '0;
            pos  <= '0;
        end else if (load) begin
            lo_q <= lo;
            hi_q <= hi;
            pos  <= lo;
        end else if (step) begin
            if (pos.x == hi_q.x) begin
                pos.x <= lo_q.x;
                pos.y <= COORD_W'(pos.y + COORD_W'(1));
            end else begin
                pos.x <= COORD_W'(pos.x + COORD_W'(1));
            end
        end
    end

    assign last_c = (pos.x == hi_q.x) && (pos.y == hi_q.y);

endmodule

// File: rtl/laser_scan_ctrl.sv
// laser_scan_ctrl: two-circle coverage search sequencer (scan, then alternating refinement).
// Build option LASER_EARLY_EXIT_EN: finish on a pass with no gain or on full coverage.
module laser_scan_ctrl
    import laser_pkg::*;
#(
    parameter int unsigned WIN      = 3,
    parameter int unsigned MAX_PASS = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    output logic               BUSY,
    output logic               DONE,
    output logic               EVAL_VALID,
    input  logic               EVAL_READY,
    output logic [COORD_W-1:0] EVAL_CX,
    output logic [COORD_W-1:0] EVAL_CY,
    output logic [COORD_W-1:0] EVAL_FX,
    output logic [COORD_W-1:0] EVAL_FY,
    output logic               EVAL_USE_FIXED,
    input  logic               RES_VALID,
    input  logic [CNT_W-1:0]   RES_COUNT,
    output logic [COORD_W-1:0] C1X,
    output logic [COORD_W-1:0] C1Y,
    output logic [COORD_W-1:0] C2X,
    output logic [COORD_W-1:0] C2Y,
    output logic [CNT_W-1:0]   BEST_CNT
);

    localparam int unsigned PASS_W = 4;
    localparam logic [COORD_W-1:0] WIN_C    = COORD_W'(WIN);
    localparam logic [PASS_W-1:0]  PASS_C   = PASS_W'(MAX_PASS);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(NPTS);
    localparam coord_t GRID_LO = '0;
    localparam coord_t GRID_HI = {COORD_W'(GRID_MAX), COORD_W'(GRID_MAX)};
`ifdef LASER_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t            state, state_n;
    coord_t            c1, c1_n, c2, c2_n, fix, fix_n;
    logic [CNT_W-1:0]  c1_cnt, c1_cnt_n, best, best_n, prev_best, prev_best_n;
    logic [PASS_W-1:0] pass_cnt, pass_n;
    logic              eval_valid, eval_valid_n, waiting, waiting_n;
    logic              use_fixed, use_fixed_n, busy, busy_n, done, done_n;
    logic              gen_load, gen_step, gen_last_c, stop_now, pass_stop;
    coord_t            gen_lo, gen_hi, cand;

    laser_win_gen u_win (
        .CLK    (CLK),
        .RST    (RST),
        .load   (gen_load),
        .step   (gen_step),
        .lo     (gen_lo),
        .hi     (gen_hi),
        .pos    (cand),
        .last_c (gen_last_c)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            c1         <= '0;
            c2         <= '0;
            fix        <= '0;
            c1_cnt     <= '0;
            best       <= '0;
            prev_best  <= '0;
            pass_cnt   <= '0;
            eval_valid <= 1'b0;
            waiting    <= 1'b0;
            use_fixed  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            c1         <= c1_n;
            c2         <= c2_n;
            fix        <= fix_n;
            c1_cnt     <= c1_cnt_n;
            best       <= best_n;
            prev_best  <= prev_best_n;
            pass_cnt   <= pass_n;
            eval_valid <= eval_valid_n;
            waiting    <= waiting_n;
            use_fixed  <= use_fixed_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Next-state: handshake, best-centre tracking and phase sequencing.
    always_comb begin
        state_n      = state;
        c1_n         = c1;
        c2_n         = c2;
        fix_n        = fix;
        c1_cnt_n     = c1_cnt;
        best_n       = best;
        prev_best_n  = prev_best;
        pass_n       = pass_cnt;
        eval_valid_n = eval_valid;
        waiting_n    = waiting;
        use_fixed_n  = use_fixed;
        busy_n       = busy;
        done_n       = 1'b0;
        gen_load     = 1'b0;
        gen_step     = 1'b0;
        gen_lo       = GRID_LO;
        gen_hi       = GRID_HI;
        stop_now     = 1'b0;
        pass_stop    = 1'b0;

        unique case (state)
            IDLE: begin
                if (START) begin
                    state_n      = SCAN1;
                    busy_n       = 1'b1;
                    eval_valid_n = 1'b1;
                    c1_cnt_n     = '0;
                    best_n       = '0;
                    prev_best_n  = '0;
                    pass_n       = '0;
                    use_fixed_n  = 1'b0;
                    fix_n        = '0;
                    gen_load     = 1'b1;
                end
            end
            FIN: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                if (eval_valid && EVAL_READY) begin
                    eval_valid_n = 1'b0;
                    waiting_n    = 1'b1;
                end else if (waiting && RES_VALID) begin
                    waiting_n = 1'b0;
                    if (state == SCAN1) begin
                        if (RES_COUNT >= c1_cnt) begin
                            c1_n     = cand;
                            c1_cnt_n = RES_COUNT;
                        end
                    end else if (RES_COUNT >= best) begin
                        best_n = RES_COUNT;
                        if (state == SCAN2 || state == REF2) begin
                            c2_n = cand;
                        end else begin
                            c1_n = cand;
                        end
                    end
                    // A full-coverage result is always recorded, so it can end the search.
                    stop_now = EARLY_EXIT && (RES_COUNT == FULL_CNT);
                    if (stop_now) begin
                        best_n  = RES_COUNT;
                        state_n = FIN;
                        done_n  = 1'b1;
                    end else if (!gen_last_c) begin
                        gen_step     = 1'b1;
                        eval_valid_n = 1'b1;
                    end else begin
                        eval_valid_n = 1'b1;
                        gen_load     = 1'b1;
                        case (state)
                            SCAN1: begin
                                state_n     = SCAN2;
                                fix_n       = c1_n;
                                use_fixed_n = 1'b1;
                            end
                            SCAN2: begin
                                state_n     = REF1;
                                prev_best_n = best_n;
                                fix_n       = c2_n;
                                gen_lo      = win_lo(c1_n, WIN_C);
                                gen_hi      = win_hi(c1_n, WIN_C);
                            end
                            REF1: begin
                                state_n = REF2;
                                fix_n   = c1_n;
                                gen_lo  = win_lo(c2_n, WIN_C);
                                gen_hi  = win_hi(c2_n, WIN_C);
                            end
                            default: begin
                                pass_n      = PASS_W'(pass_cnt + PASS_W'(1));
                                prev_best_n = best_n;
                                pass_stop   = (pass_n == PASS_C) ||
                                              (EARLY_EXIT && ((best_n == prev_best) ||
                                                              (best_n == FULL_CNT)));
                                if (pass_stop) begin
                                    state_n      = FIN;
                                    done_n       = 1'b1;
                                    eval_valid_n = 1'b0;
                                    gen_load     = 1'b0;
                                end else begin
                                    state_n = REF1;
                                    fix_n   = c2_n;
                                    gen_lo  = win_lo(c1_n, WIN_C);
                                    gen_hi  = win_hi(c1_n, WIN_C);
                                end
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    assign BUSY           = busy;
    assign DONE           = done;
    assign EVAL_VALID     = eval_valid;
    assign EVAL_CX        = cand.x;
    assign EVAL_CY        = cand.y;
    assign EVAL_FX        = fix.x;
    assign EVAL_FY        = fix.y;
    assign EVAL_USE_FIXED = use_fixed;
    assign C1X            = c1.x;
    assign C1Y            = c1.y;
    assign C2X            = c2.x;
    assign C2Y            = c2.y;
    assign BEST_CNT       = best;

endmodule
